// File: rtl/data_mem_responder_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// data_mem_responder_pkg: shared encodings and constants | Rev 1.0
// ----------------------------------------------------------------------------
package data_mem_responder_pkg;

  typedef logic [31:0] word_t;

  localparam logic [1:0] DM_IDLE    = 2'b00;
  localparam logic [1:0] DM_RD_WAIT = 2'b01;
  localparam logic [1:0] DM_ACK     = 2'b10;

  localparam word_t ZeroWord     = 32'h0000_0000;
  localparam logic  WriteEnable  = 1'b1;
  localparam logic  WriteDisable = 1'b0;

  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 7;

  function automatic int clamp_latency(input int lat);
    if (lat < READ_LATENCY_MIN) return READ_LATENCY_MIN;
    if (lat > READ_LATENCY_MAX) return READ_LATENCY_MAX;
    return lat;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// data_mem_responder_if: MEM-stage load/store bus | Rev 1.0
// ----------------------------------------------------------------------------
interface data_mem_responder_if;
  import data_mem_responder_pkg::*;

  logic       mem_ce_i;
  logic       mem_we_i;
  word_t      mem_addr_i;
  logic [3:0] mem_sel_i;
  word_t      mem_data_i;
  word_t      mem_data_o;
  logic       mem_ack_o;
  logic       mem_err_o;
  logic       stall_req_o;

  modport master (
    output mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
    input  mem_data_o, mem_ack_o, mem_err_o, stall_req_o
  );

  modport slave (
    input  mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
    output mem_data_o, mem_ack_o, mem_err_o, stall_req_o
  );
endinterface
`default_nettype wire

// File: rtl/data_mem_responder_ram_array.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dm_ram_array: single-port RAM, byte-enable write, registered read | Rev 1.0
// ----------------------------------------------------------------------------
module dm_ram_array #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [3:0]            sel,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] r_mem [0:(1<<ADDR_WIDTH)-1];

  // Read-first: a read at the write edge returns the old word.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (sel[i]) r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata <= r_mem[addr];
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// data_mem_responder: data-memory slave with read latency and ack | Rev 1.0
// ----------------------------------------------------------------------------
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus
);

  localparam int         c_LAT      = clamp_latency(READ_LATENCY);
  localparam logic [2:0] c_CNT_INIT = 3'((c_LAT > 1) ? (c_LAT - 2) : 0);

  logic [1:0]            r_state;
  logic [2:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic                  r_load;
  logic                  r_err;
  word_t                 r_data;

  logic                  w_idle;
  logic                  w_ack;
  logic                  w_misaligned;
  logic                  w_ram_we;
  logic [ADDR_WIDTH-1:0] w_req_idx;
  logic [ADDR_WIDTH-1:0] w_ram_addr;
  word_t                 w_ram_rdata;
  logic                  w_unused_addr;

  assign w_idle        = (r_state == DM_IDLE);
  assign w_ack         = (r_state == DM_ACK);
  assign w_misaligned  = is_misaligned(bus.mem_addr_i[1:0]);
  assign w_req_idx     = bus.mem_addr_i[ADDR_WIDTH+1:2];
  assign w_unused_addr = ^bus.mem_addr_i[31:ADDR_WIDTH+2];
  assign w_ram_we      = (w_idle && bus.mem_ce_i && bus.mem_we_i && !w_misaligned)
                         ? WriteEnable : WriteDisable;
  // The RAM output register lands on the edge that enters ACK, so the array
  // must see the captured index throughout RD_WAIT.
  assign w_ram_addr    = w_idle ? w_req_idx : r_idx;

  dm_ram_array #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (w_ram_we),
    .sel   (bus.mem_sel_i),
    .addr  (w_ram_addr),
    .wdata (bus.mem_data_i),
    .rdata (w_ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= DM_IDLE;
      r_cnt   <= 3'd0;
      r_idx   <= '0;
      r_load  <= 1'b0;
      r_err   <= 1'b0;
      r_data  <= ZeroWord;
    end else begin
      case (r_state)
        DM_IDLE: begin
          if (bus.mem_ce_i) begin
            if (w_misaligned) begin
              r_state <= DM_ACK;
              r_err   <= 1'b1;
              r_load  <= 1'b0;
              r_data  <= ZeroWord;
            end else if (bus.mem_we_i) begin
              r_state <= DM_ACK;
              r_load  <= 1'b0;
            end else begin
              r_idx  <= w_req_idx;
              r_load <= 1'b1;
              if (c_LAT == 1) begin
                r_state <= DM_ACK;
              end else begin
                r_state <= DM_RD_WAIT;
                r_cnt   <= c_CNT_INIT;
              end
            end
          end
        end
        DM_RD_WAIT: begin
          if (r_cnt == 3'd0) r_state <= DM_ACK;
          else               r_cnt   <= r_cnt - 3'd1;
        end
        DM_ACK: begin
          r_state <= DM_IDLE;
          r_err   <= 1'b0;
          r_load  <= 1'b0;
          if (r_load) r_data <= w_ram_rdata;
        end
        default: r_state <= DM_IDLE;
      endcase
    end
  end

  // During a load ack the word comes straight from the RAM output register;
  // r_data keeps it afterwards so the value holds until the next load/err ack.
  assign bus.mem_data_o  = (w_ack && r_load) ? w_ram_rdata : r_data;
  assign bus.mem_ack_o   = w_ack;
  assign bus.mem_err_o   = r_err;
  assign bus.stall_req_o = (w_idle && bus.mem_ce_i) || (r_state == DM_RD_WAIT);

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory slave at the far end of the MEM stage's load/store interface; services word-aligned loads and byte-enabled stores.
- Owns a single-port on-chip RAM, applies a configurable read latency, and returns data with a one-cycle ack pulse.
- Raises a stall request so the pipeline holds the request stable until it is acked.
- Sits between the MEM stage and the data RAM in the top-level CPU.

Parameters:
- ADDR_WIDTH, 10: word-address bits; the array holds 2^ADDR_WIDTH 32-bit words.
- READ_LATENCY, 2: cycles from read-request acceptance to ack; legal range 1..7.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- mem_ce_i  input  1  request valid.
- mem_we_i  input  1  1 = store, 0 = load.
- mem_addr_i  input  32  byte address.
- mem_sel_i  input  4  byte-lane enables for stores; bit0 = bits 7:0.
- mem_data_i  input  32  store data.
- mem_data_o  output  32  load data; valid while mem_ack_o = 1.
- mem_ack_o  output  1  one-cycle completion pulse.
- mem_err_o  output  1  misaligned-access flag; valid with mem_ack_o.
- stall_req_o  output  1  tells the pipeline to hold the request.

Behaviour:
- Reset (async, any time, including mid-read):
  - state = IDLE, counter = 0.
  - mem_data_o = 0, mem_ack_o = 0, mem_err_o = 0.
  - RAM contents are not cleared.
- Word index = mem_addr_i[ADDR_WIDTH+1:2]. Upper address bits are ignored, so accesses alias (wrap) modulo the array size.
- Misaligned = mem_addr_i[1:0] != 0.
- States: IDLE, RD_WAIT, ACK.
- IDLE, mem_ce_i = 0: remain in IDLE.
- IDLE, mem_ce_i = 1 and misaligned:
  - No array access.
  - Go to ACK with mem_err_o = 1 and mem_data_o = 0.
- IDLE, mem_ce_i = 1, mem_we_i = 1, aligned:
  - At that edge, write each byte lane whose mem_sel_i bit is 1; other lanes are unchanged.
  - Go to ACK. Ack appears at T+1.
  - mem_sel_i = 0 is legal: acked, no bytes change.
- IDLE, mem_ce_i = 1, mem_we_i = 0, aligned:
  - Capture the word index.
  - If READ_LATENCY = 1: register the array word into mem_data_o and go to ACK.
  - Otherwise: load counter = READ_LATENCY-2 and go to RD_WAIT.
- RD_WAIT:
  - If counter = 0: register the array word at the captured index into mem_data_o and go to ACK.
  - Otherwise: decrement counter.
  - Load ack therefore appears at T+READ_LATENCY.
- ACK:
  - mem_ack_o = 1 for exactly this cycle.
  - Always return to IDLE.
  - mem_err_o clears on leaving ACK.
  - mem_data_o holds its value until the next load/err ack.
- Loads return the full word regardless of mem_sel_i; the MEM stage extracts sub-words.
- stall_req_o (combinational) = (IDLE & mem_ce_i) | RD_WAIT; it is 0 in ACK.
- Initiator rule: address, data, sel and we are held stable from the request until the ack cycle inclusive. Changes before ack are undefined behaviour and are flagged by a bench assertion.
- mem_ce_i still high in IDLE after an ACK is treated as a new request. The pipeline advances at the end of the ACK cycle.
- Read-after-write to the same word returns the new data; the write commits before the next request is sampled.
- No outstanding-request queue: one access in flight at a time.

Decomposition:
- Shared package holds:
  - state encodings DM_IDLE, DM_RD_WAIT, DM_ACK;
  - ZeroWord, WriteEnable, WriteDisable;
  - READ_LATENCY legal-range constants.
- One natural sub-module, dm_ram_array:
  - synchronous single-port RAM with byte-enable write and registered read;
  - ports: clk, we, sel[3:0], addr[ADDR_WIDTH-1:0], wdata, rdata.
- data_mem_responder holds the FSM, the latency counter and the output registers.

Test Plan:
1. rst high mid-read (RD_WAIT) -> outputs go to 0 immediately with no clock edge; state returns to IDLE; a subsequent read of any previously stored word returns the stored value.
2. Store addr 0x0000_0010, sel 4'b1111, data 0xDEADBEEF; then load 0x10 with READ_LATENCY = 2:
   - store ack at T+1, stall_req_o = 1 only in the request cycle;
   - load ack 2 cycles after acceptance, mem_data_o = 0xDEADBEEF.
3. Byte-lane store to 0x10, sel 4'b0100, data 0x00AA0000 -> a subsequent load returns 0xDEAABEEF.
4. Load 0x0000_0013 -> ack at T+1 with mem_err_o = 1, mem_data_o = 0; the array is untouched (a re-read of 0x10 is unchanged).
5. Aliasing with ADDR_WIDTH = 10: store 0x1234_5678 to 0x0000_1010 -> a load of 0x0000_0010 returns 0x1234_5678.
6. Back-to-back sweep with READ_LATENCY = 1 and 7:
   - the ack count equals the request count;
   - no ack pulse is longer than 1 cycle;
   - stall_req_o is never high in an ack cycle.
